// File: rtl/uart_pkg.sv
// Shared types and sizing constants for the UART word receiver.
// The FSM enum is used by uart_rx; word sizing by uart_word_rx.
package uart_pkg;

   localparam int BYTES_PER_WORD = 4;
   localparam int BITS_PER_BYTE  = 8;
   localparam int TIMEOUT_BITS   = 16;

   // BREAK parks the FSM after a bad stop bit until the line returns high
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, half-bit start check,
// mid-bit sampling; flags good bytes and framing errors for one cycle.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 5208
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rxd,
   output logic [BITS_PER_BYTE-1:0] byte_data,
   output logic                     byte_valid,
   output logic                     byte_ferr,
   output logic                     idle
);

   localparam int TW = $clog2(2 * CLK_PER_HALF_BIT);
   localparam logic [TW-1:0] HALF_END = TW'(CLK_PER_HALF_BIT - 1);
   localparam logic [TW-1:0] FULL_END = TW'(2 * CLK_PER_HALF_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_BYTE - 1);

   logic [1:0]               sync;
   logic                     rx;
   rx_state_e                state;
   rx_state_e                next;
   logic [TW-1:0]            timer;
   logic [2:0]               bit_cnt;
   logic [BITS_PER_BYTE-1:0] shreg;
   logic                     half_tick;
   logic                     full_tick;
   logic                     timer_clr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync <= 2'b11;
      else        sync <= {sync[0], rxd};
   end

   assign rx        = sync[1];
   assign half_tick = (timer == HALF_END);
   assign full_tick = (timer == FULL_END);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next;
   end

   always_comb begin
      next = state;
      unique case (state)
         ST_IDLE:  if (!rx) next = ST_START;
         ST_START: if (half_tick) next = rx ? ST_IDLE : ST_DATA;
         ST_DATA:  if (full_tick && bit_cnt == LAST_BIT) next = ST_STOP;
         ST_STOP:  if (full_tick) next = rx ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rx) next = ST_IDLE;
         default:  next = ST_IDLE;
      endcase
   end

   always_comb begin
      byte_valid = (state == ST_STOP) && full_tick && rx;
      byte_ferr  = (state == ST_STOP) && full_tick && !rx;
      idle       = (state == ST_IDLE);
      byte_data  = shreg;
   end

   // timer restarts on every state change and at each data-bit sample
   assign timer_clr = (next != state) || (state == ST_IDLE) ||
                      (state == ST_BREAK) ||
                      ((state == ST_DATA) && full_tick);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         timer <= '0;
      else if (timer_clr) timer <= '0;
      else                timer <= timer + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                bit_cnt <= '0;
      else if (state != ST_DATA) bit_cnt <= '0;
      else if (full_tick)        bit_cnt <= bit_cnt + 3'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         shreg <= '0;
      else if (state == ST_DATA && full_tick)
         shreg <= {rx, shreg[BITS_PER_BYTE-1:1]};
   end

endmodule

// File: rtl/uart_word_rx.sv
// Assembles four UART bytes into a little-endian 32-bit word.
// Optional inter-byte timeout under UART_WORD_RX_TIMEOUT_EN.
module uart_word_rx
   import uart_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 5208
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rxd,
   output logic [31:0] rdata,
   output logic        rdata_ready,
   output logic        ferr
);

   localparam int       PW       = (BYTES_PER_WORD - 1) * BITS_PER_BYTE;
   localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

   logic [BITS_PER_BYTE-1:0] byte_data;
   logic                     byte_valid;
   logic                     byte_ferr;
   logic                     rx_idle;
   logic [1:0]               byte_cnt;
   logic [PW-1:0]            partial;

   uart_rx #(
      .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
   ) u_rx (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .byte_data (byte_data),
      .byte_valid(byte_valid),
      .byte_ferr (byte_ferr),
      .idle      (rx_idle)
   );

`ifdef UART_WORD_RX_TIMEOUT_EN
   localparam int TO_CLKS = 2 * TIMEOUT_BITS * CLK_PER_HALF_BIT;
   localparam int TOW     = $clog2(TO_CLKS);

   logic [TOW-1:0] to_cnt;
   logic           timeout;

   assign timeout = (to_cnt == TOW'(TO_CLKS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         to_cnt <= '0;
      else if (!rx_idle || byte_cnt == 2'd0 || timeout)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + 1'b1;
   end
`else
   logic unused_idle;
   assign unused_idle = rx_idle;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt    <= '0;
         partial     <= '0;
         rdata       <= '0;
         rdata_ready <= 1'b0;
         ferr        <= 1'b0;
      end else begin
         rdata_ready <= 1'b0;
         ferr        <= byte_ferr;
         if (byte_ferr) begin
            byte_cnt <= '0;
         end else if (byte_valid) begin
            if (byte_cnt == LAST_BYTE) begin
               rdata       <= {byte_data, partial};
               rdata_ready <= 1'b1;
               byte_cnt    <= '0;
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
               unique case (byte_cnt)
                  2'd0:    partial[7:0]   <= byte_data;
                  2'd1:    partial[15:8]  <= byte_data;
                  default: partial[23:16] <= byte_data;
               endcase
            end
         end
`ifdef UART_WORD_RX_TIMEOUT_EN
         else if (timeout) begin
            byte_cnt <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed + randomized bench for uart_word_rx with a byte-queue model.
// Honours UART_WORD_RX_TIMEOUT_EN when predicting the timeout case.
module tb_uart_word_rx;

   localparam int HALF = 4;
   localparam int BITC = 2 * HALF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rxd = 1'b1;
   logic [31:0] rdata;
   logic        rdata_ready;
   logic        ferr;

   uart_word_rx #(.CLK_PER_HALF_BIT(HALF)) dut (
      .clk        (clk),
      .reset      (reset),
      .rxd        (rxd),
      .rdata      (rdata),
      .rdata_ready(rdata_ready),
      .ferr       (ferr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [7:0]  q_bytes[$];
   logic [31:0] exp_words[$];
   logic [31:0] obs_words[$];
   logic [31:0] exp_rdata = '0;
   int          exp_ferr = 0;
   int          obs_ferr = 0;
   int          both_cnt = 0;
   int          long_cnt = 0;
   int          done = 0;
   logic        prev_ready = 1'b0;

   always @(negedge clk) begin
      if (rdata_ready) obs_words.push_back(rdata);
      if (ferr) obs_ferr++;
      if (ferr && rdata_ready) both_cnt++;
      if (rdata_ready && prev_ready) long_cnt++;
      prev_ready = rdata_ready;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      q_bytes.push_back(b);
      if (q_bytes.size() == 4) begin
         exp_rdata = {q_bytes[3], q_bytes[2], q_bytes[1], q_bytes[0]};
         exp_words.push_back(exp_rdata);
         q_bytes.delete();
      end
   endtask

   task automatic line_bit(input logic v);
      rxd = v;
      repeat (BITC) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      rxd = 1'b1;
      repeat (n * BITC) @(negedge clk);
`ifdef UART_WORD_RX_TIMEOUT_EN
      if (n >= 16) q_bytes.delete();
`endif
   endtask

   task automatic send(input logic [7:0] b, input logic stop_ok);
      line_bit(1'b0);
      for (int i = 0; i < 8; i++) line_bit(b[i]);
      line_bit(stop_ok);
      if (stop_ok) begin
         model_byte(b);
      end else begin
         exp_ferr++;
         q_bytes.delete();
         idle_bits(1);
      end
   endtask

   task automatic scen(input string tag);
      idle_bits(3);
      chk({tag, ".words"}, 32'(obs_words.size()), 32'(exp_words.size()));
      for (int i = done; i < exp_words.size() && i < obs_words.size(); i++)
         chk({tag, ".word"}, obs_words[i], exp_words[i]);
      done = exp_words.size();
      chk({tag, ".ferr"}, 32'(obs_ferr), 32'(exp_ferr));
      chk({tag, ".both"}, 32'(both_cnt), 32'd0);
      chk({tag, ".width"}, 32'(long_cnt), 32'd0);
      chk({tag, ".rdata"}, rdata, exp_rdata);
   endtask

   initial begin
      logic [7:0] b;
      logic       ok;
      int         gap;

      repeat (3) @(negedge clk);
      chk("rst.rdata", rdata, 32'h0);
      chk("rst.ready", {31'd0, rdata_ready}, 32'd0);
      chk("rst.ferr", {31'd0, ferr}, 32'd0);
      reset = 1'b1;
      idle_bits(2);

      send(8'h78, 1'b1); send(8'h56, 1'b1);
      send(8'h34, 1'b1); send(8'h12, 1'b1);
      scen("basic");

      rxd = 1'b0;
      repeat (2) @(negedge clk);
      idle_bits(3);
      send(8'hEF, 1'b1); send(8'hBE, 1'b1);
      send(8'hAD, 1'b1); send(8'hDE, 1'b1);
      scen("glitch");

      send(8'h11, 1'b1); send(8'h22, 1'b0);
      send(8'hEF, 1'b1); send(8'hBE, 1'b1);
      send(8'hAD, 1'b1); send(8'hDE, 1'b1);
      scen("framing");

      send(8'hAA, 1'b1); send(8'hBB, 1'b1);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid.rdata", rdata, 32'h0);
      chk("mid.ready", {31'd0, rdata_ready}, 32'd0);
      reset = 1'b1;
      q_bytes.delete();
      exp_rdata = '0;
      idle_bits(1);
      send(8'h01, 1'b1); send(8'h02, 1'b1);
      send(8'h03, 1'b1); send(8'h04, 1'b1);
      scen("reset");

      for (int i = 0; i < 8; i++) send(8'(i), 1'b1);
      scen("b2b");

      send(8'h99, 1'b1);
      idle_bits(20);
      send(8'h01, 1'b1); send(8'h02, 1'b1);
      send(8'h03, 1'b1); send(8'h04, 1'b1);
      scen("timeout");

      for (int i = 0; i < 40; i++) begin
         b   = 8'($urandom);
         ok  = ($urandom_range(0, 7) != 0);
         gap = $urandom_range(0, 3);
         send(b, ok);
         if (gap > 0) idle_bits(gap);
      end
      scen("random");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 5208, clocks per half UART bit period (minimum 2).
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port rxd  input  1  asynchronous UART serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rdata  output  32  most recently assembled word.
REQ-006 SHALL have port rdata_ready  output  1  one-cycle pulse when rdata is updated.
REQ-007 SHALL have port ferr  output  1  one-cycle pulse on framing error or glitch-free stop-bit failure.

Function
REQ-008 SHALL pass rxd through a 2-flop synchronizer (flops reset to 1) before any use.
REQ-009 SHALL implement byte FSM states IDLE, START, DATA, STOP.
REQ-010 IDLE -> START on synchronized rxd = 0; bit-timer cleared.
REQ-011 START: after CLK_PER_HALF_BIT clocks sample rxd; 0 -> DATA; 1 -> IDLE (glitch, no ferr, no byte).
REQ-012 DATA: sample every 2*CLK_PER_HALF_BIT clocks, 8 samples, shift in LSB first; then -> STOP.
REQ-013 STOP: after 2*CLK_PER_HALF_BIT clocks sample rxd; 1 -> byte valid, -> IDLE same cycle (back-to-back bytes with zero idle supported).
REQ-014 STOP sample 0 -> ferr pulse, byte discarded, partial word discarded (byte count = 0), FSM waits for rxd = 1 before entering IDLE.
REQ-015 Word assembly little-endian: first valid byte -> rdata[7:0], fourth -> rdata[31:24].
REQ-016 Byte count 0..3, wraps to 0 on fourth valid byte.
REQ-017 On fourth valid byte, rdata and rdata_ready update in the cycle after the stop-bit sample edge; latency fixed at 1 clock.
REQ-018 rdata holds its value between updates; partial bytes never visible on rdata.
REQ-019 rdata_ready and ferr SHALL never be asserted in the same cycle.

Reset
REQ-020 Reset asserted: FSM = IDLE, byte count = 0, bit-timer = 0, shift register = 0, rdata = 0, rdata_ready = 0, ferr = 0, synchronizer = 1.
REQ-021 Reset mid-byte or mid-word discards all partial data; first byte after release is byte 0.

Configuration
REQ-022 Macro UART_WORD_RX_TIMEOUT_EN, when defined, SHALL add an inter-byte timeout counter.
REQ-023 With UART_WORD_RX_TIMEOUT_EN: if byte count != 0 and FSM idle for 16 bit periods (32*CLK_PER_HALF_BIT clocks), byte count resets to 0 with no output pulse.
REQ-024 Without UART_WORD_RX_TIMEOUT_EN: partial words held indefinitely; no timeout logic synthesized.

Structure
REQ-025 Package uart_pkg SHALL hold the FSM state enum typedef, BYTES_PER_WORD = 4, BITS_PER_BYTE = 8, TIMEOUT_BITS = 16.
REQ-026 SHALL instantiate one sub-module uart_rx (synchronizer + byte FSM, outputs byte, byte_valid, byte_ferr); word assembly and timeout live in uart_word_rx.

Verification (bench uses CLK_PER_HALF_BIT = 4)
REQ-027 Send 0x78,0x56,0x34,0x12 -> rdata = 0x12345678, rdata_ready high exactly 1 cycle, ferr never high.
REQ-028 Pulse rxd low 2 clocks in IDLE, then send 0xEF,0xBE,0xAD,0xDE -> no ferr, single word 0xDEADBEEF.
REQ-029 Send 0x11, then 0x22 with stop bit 0, then 0xEF,0xBE,0xAD,0xDE -> one ferr pulse, then rdata = 0xDEADBEEF.
REQ-030 Send 0xAA,0xBB, assert reset 3 clocks, send 0x01,0x02,0x03,0x04 -> rdata = 0x04030201, no earlier pulse.
REQ-031 Send 8 bytes 0x00..0x07 with zero idle between frames -> rdata_ready twice: 0x03020100 then 0x07060504.
REQ-032 With UART_WORD_RX_TIMEOUT_EN: send 0x99, idle 20 bit periods, send 0x01..0x04 -> rdata = 0x04030201; without macro -> rdata = 0x03020199.
